// File: rtl/vga_fetch_if.sv
// SRAM arbiter read port used by the VGA frame fetcher.
// master: the fetcher (drives address/request); slave: the arbiter.
interface vga_fetch_if;
  logic [19:0] sram_addr;
  logic        sram_sel;
  logic [47:0] sram_data;
  logic        sram_valid;

  modport master (
    output sram_addr,
    output sram_sel,
    input  sram_data,
    input  sram_valid
  );

  modport slave (
    input  sram_addr,
    input  sram_sel,
    output sram_data,
    output sram_valid
  );
endinterface

// File: rtl/vga_fetch.sv
// VGA frame fetcher: reads 48-bit words (4 x 12-bit pixels) from SRAM through
// the arbiter VGA port into a small FIFO and presents one pixel at a time to
// scan-out with zero latency.
// Optional feature: define VGA_FETCH_UNDERRUN_EN to build the sticky underrun
// detector; otherwise o_underrun is tied to 0.
module vga_fetch #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          FRAME_WORDS = 76800,
  parameter int          DEPTH_LOG2  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_start,
  vga_fetch_if.master   bus,
  input  logic          i_pix_rd,
  output logic [11:0]   o_pix_data,
  output logic          o_pix_empty,
  output logic          o_underrun
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
  localparam logic [19:0]           LAST_ADDR = 20'(BASE_ADDR + 20'(FRAME_WORDS) - 20'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [19:0]           r_addr;
  logic                  r_sel;
  logic [47:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [1:0]            r_pix_idx;
  logic                  w_empty;
  logic                  w_capture;
  logic                  w_pix_adv;
  logic                  w_pop;
  logic                  w_last;
  logic [47:0]           w_head;

  // A capture only counts in FETCH, and a same-cycle frame_start discards it.
  assign w_empty   = (r_count == CNT_ZERO);
  assign w_capture = (r_state == ST_FETCH) && bus.sram_valid && !i_frame_start;
  assign w_pix_adv = i_pix_rd && !w_empty && !i_frame_start;
  assign w_pop     = w_pix_adv && (r_pix_idx == 2'd3);
  assign w_last    = (r_addr == LAST_ADDR);

  assign bus.sram_addr = r_addr;
  assign bus.sram_sel  = r_sel;
  assign o_pix_empty   = w_empty;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_capture, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state logic; frame_start restarts fetching from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (i_frame_start) begin
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_FETCH: begin
          if (w_capture && w_last) begin
            w_state_nxt = ST_IDLE;
          end else if (w_capture && (w_count_nxt == CNT_FULL)) begin
            w_state_nxt = ST_FULL;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_FULL: begin
          if (r_count < CNT_FULL) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register plus registered request that mirrors the FETCH state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= (w_state_nxt == ST_FETCH);
    end
  end

  // Request address: held until a word is captured, then advances by one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= BASE_ADDR;
    end else if (i_frame_start) begin
      r_addr <= BASE_ADDR;
    end else if (w_capture) begin
      r_addr <= r_addr + 20'd1;
    end else begin
      r_addr <= r_addr;
    end
  end

  // FIFO pointers, occupancy and pixel index within the head word.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_frame_start) begin
      r_wr_ptr  <= PTR_ZERO;
      r_rd_ptr  <= PTR_ZERO;
      r_count   <= CNT_ZERO;
      r_pix_idx <= 2'd0;
    end else begin
      r_count <= w_count_nxt;
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pix_adv) begin
        r_pix_idx <= r_pix_idx + 2'd1;
      end else begin
        r_pix_idx <= r_pix_idx;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= bus.sram_data;
    end
  end

  // Zero-latency pixel slice of the head word; blank while empty.
  always_comb begin
    w_head     = r_mem[r_rd_ptr];
    o_pix_data = 12'h000;
    if (w_empty) begin
      o_pix_data = 12'h000;
    end else begin
      case (r_pix_idx)
        2'd0:    o_pix_data = w_head[11:0];
        2'd1:    o_pix_data = w_head[23:12];
        2'd2:    o_pix_data = w_head[35:24];
        2'd3:    o_pix_data = w_head[47:36];
        default: o_pix_data = 12'h000;
      endcase
    end
  end

`ifdef VGA_FETCH_UNDERRUN_EN
  logic r_underrun;

  // Sticky underrun: scan-out asked for a pixel that was not there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_underrun <= 1'b0;
    end else if (i_frame_start) begin
      r_underrun <= 1'b0;
    end else if (i_pix_rd && w_empty) begin
      r_underrun <= 1'b1;
    end else begin
      r_underrun <= r_underrun;
    end
  end

  assign o_underrun = r_underrun;
`else
  assign o_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fetch.sv
// Scoreboard bench for vga_fetch: a random arbiter/scan-out drives the DUT,
// captured words are pushed as expected pixels into a queue, and a monitor on
// the falling edge pops and compares whatever the DUT presents.
module tb_vga_fetch;
  localparam logic [19:0] BASE  = 20'h00040;
  localparam int          FW    = 24;
  localparam int          DL    = 4;
  localparam int          DEPTH = 16;
`ifdef VGA_FETCH_UNDERRUN_EN
  localparam logic        UR_EN = 1'b1;
`else
  localparam logic        UR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        rd;
  logic [11:0] pix;
  logic        empty;
  logic        under;

  vga_fetch_if sif ();

  vga_fetch #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_start(fs),
    .bus          (sif),
    .i_pix_rd     (rd),
    .o_pix_data   (pix),
    .o_pix_empty  (empty),
    .o_underrun   (under)
  );

  always #5 clk = ~clk;

  // Reference model: pixel stream in display order plus fetch bookkeeping.
  logic [11:0] pixq[$];
  logic [19:0] exp_addr;
  int          fetched;
  bit          started;
  logic        exp_under;
  bit          mon_en;
  bit          idle_prev;
  int          n_checks;
  int          n_fail;

  bit          p_push;
  bit          p_fs;
  bit          p_rs;
  logic [47:0] p_word;

  function automatic void check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Apply what the DUT did at the edge just passed to the model.
  task automatic commit();
    if (p_rs) begin
      pixq.delete();
      fetched  = 0;
      started  = 1'b0;
      exp_addr = BASE;
    end else if (p_fs) begin
      pixq.delete();
      fetched  = 0;
      started  = 1'b1;
      exp_addr = BASE;
    end else if (p_push) begin
      for (int k = 0; k < 4; k++) pixq.push_back(p_word[12*k +: 12]);
      fetched++;
      exp_addr = exp_addr + 20'd1;
    end
  endtask

  // One clock of stimulus, entered and left at posedge+1.
  task automatic step(input bit s_rd, input bit s_vld, input bit s_fs, input bit s_rs, input logic [47:0] data);
    rd  = s_rd;
    fs  = s_fs;
    rst = s_rs;
    sif.sram_valid = s_vld;
    sif.sram_data  = data;
    p_rs   = s_rs;
    p_fs   = s_fs;
    p_push = s_vld && sif.sram_sel && !s_fs && !s_rs;
    p_word = data;
    @(posedge clk);
    #1;
    commit();
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // Monitor: compares presented pixels, emptiness, request and underrun.
  always @(negedge clk) begin
    int          words;
    logic [11:0] e;
    if (mon_en) begin
      words = (pixq.size() + 3) / 4;
      check("pix_empty", {47'd0, empty}, {47'd0, (pixq.size() == 0)});
      if (empty) check("pix_blank", {36'd0, pix}, 48'd0);
      if (rd && pixq.size() > 0) begin
        e = pixq.pop_front();
        check("pix_data", {36'd0, pix}, {36'd0, e});
      end
      if (sif.sram_sel) begin
        check("sram_addr", {28'd0, sif.sram_addr}, {28'd0, exp_addr});
        check("sel_allowed", {47'd0, (started && words < DEPTH && fetched < FW)}, 48'd1);
        idle_prev = 1'b0;
      end else if (started && fetched < FW && words < DEPTH) begin
        if (idle_prev) check("sel_stalled", {47'd0, sif.sram_sel}, 48'd1);
        idle_prev = 1'b1;
      end else begin
        idle_prev = 1'b0;
      end
      check("underrun", {47'd0, under}, {47'd0, exp_under});
      if (rst || fs) exp_under = 1'b0;
      else if (rd && pixq.size() == 0 && UR_EN) exp_under = 1'b1;
      else exp_under = exp_under;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] d;
    int          guard;
    n_checks = 0; n_fail = 0; mon_en = 1'b0; idle_prev = 1'b0;
    exp_under = 1'b0; started = 1'b0; fetched = 0; exp_addr = BASE;
    p_push = 1'b0; p_fs = 1'b0; p_rs = 1'b0; p_word = 48'd0;
    rst = 1'b1; fs = 1'b0; rd = 1'b0;
    sif.sram_valid = 1'b0; sif.sram_data = 48'd0;
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 48'd0);
    mon_en = 1'b1;
    check("rst_sel", {47'd0, sif.sram_sel}, 48'd0);
    check("rst_addr", {28'd0, sif.sram_addr}, {28'd0, BASE});
    check("rst_empty", {47'd0, empty}, 48'd1);
    check("rst_pix", {36'd0, pix}, 48'd0);
    check("rst_under", {47'd0, under}, 48'd0);

    // No fetch before frame_start, even with stray valids.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd48());
    check("idle_no_sel", {47'd0, sif.sram_sel}, 48'd0);

    // Fill without reading: exactly DEPTH captures then FULL.
    step(1'b0, 1'b0, 1'b1, 1'b0, 48'd0);
    check("start_sel", {47'd0, sif.sram_sel}, 48'd1);
    for (int i = 0; i < 60; i++) begin
      d = (fetched == 0) ? 48'hFFF_ABC_123_456 : rnd48();
      step(1'b0, sif.sram_sel, 1'b0, 1'b0, d);
    end
    check("fill_count", 48'(fetched), 48'(DEPTH));
    check("fill_sel", {47'd0, sif.sram_sel}, 48'd0);
    check("head_pix0", {36'd0, pix}, 48'h456);

    // One word drained (4 pixels) lets exactly one more fetch through.
    for (int i = 0; i < 4; i++) step(1'b1, sif.sram_sel, 1'b0, 1'b0, rnd48());
    for (int i = 0; i < 10; i++) step(1'b0, sif.sram_sel, 1'b0, 1'b0, rnd48());
    check("refill_count", 48'(fetched), 48'(DEPTH + 1));
    check("refill_sel", {47'd0, sif.sram_sel}, 48'd0);

    // Drain to end of frame with a lazy arbiter.
    guard = 0;
    while ((fetched < FW || pixq.size() > 0) && guard < 1000) begin
      step(($urandom_range(0, 3) != 0), sif.sram_sel && ($urandom_range(0, 1) == 1), 1'b0, 1'b0, rnd48());
      guard++;
    end
    check("frame_words", 48'(fetched), 48'(FW));
    check("frame_end_addr", {28'd0, sif.sram_addr}, {28'd0, 20'(BASE + 20'(FW))});
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rnd48());
    check("frame_idle_sel", {47'd0, sif.sram_sel}, 48'd0);
    check("frame_idle_empty", {47'd0, empty}, 48'd1);

    // frame_start coinciding with the capture of word 7 discards it.
    step(1'b0, 1'b0, 1'b1, 1'b0, 48'd0);
    for (int i = 0; i < 40; i++) begin
      if (sif.sram_sel && sif.sram_addr == BASE + 20'd7) break;
      step(1'b0, sif.sram_sel, 1'b0, 1'b0, rnd48());
    end
    check("reach_addr7", {28'd0, sif.sram_addr}, {28'd0, BASE + 20'd7});
    step(1'b1, 1'b1, 1'b1, 1'b0, rnd48());
    check("fs_flush_empty", {47'd0, empty}, 48'd1);
    check("fs_flush_addr", {28'd0, sif.sram_addr}, {28'd0, BASE});
    check("fs_flush_sel", {47'd0, sif.sram_sel}, 48'd1);

    // Underrun: read while empty, held, cleared by frame_start.
    step(1'b1, 1'b0, 1'b0, 1'b0, 48'd0);
    check("under_set", {47'd0, under}, {47'd0, UR_EN});
    step(1'b0, 1'b0, 1'b0, 1'b0, 48'd0);
    check("under_hold", {47'd0, under}, {47'd0, UR_EN});
    step(1'b0, 1'b0, 1'b1, 1'b0, 48'd0);
    check("under_clear", {47'd0, under}, 48'd0);

    // Random traffic with occasional restarts.
    for (int i = 0; i < 2500; i++) begin
      bit f;
      f = ($urandom_range(0, 199) == 0) || (fetched == FW && pixq.size() == 0);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), f, 1'b0, rnd48());
    end

    // Reset while a request is outstanding abandons it; no restart without frame_start.
    step(1'b0, 1'b0, 1'b1, 1'b0, 48'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd48());
    check("rst_abandon_sel", {47'd0, sif.sram_sel}, 48'd0);
    check("rst_abandon_empty", {47'd0, empty}, 48'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rnd48());
    check("post_rst_sel", {47'd0, sif.sram_sel}, 48'd0);
    check("post_rst_addr", {28'd0, sif.sram_addr}, {28'd0, BASE});

    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fetch.md
VGA_FETCH -- requirements
Module: vga_fetch

Interface
REQ-001 Parameter BASE_ADDR, default 20'h00000: SRAM word address of the first frame word.
REQ-002 Parameter FRAME_WORDS, default 76800: 48-bit words per frame (640x480 12-bit pixels / 4).
REQ-003 Parameter DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 words.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse: flush and restart fetch at BASE_ADDR.
REQ-007 sram_addr  output  20  word address presented to the SRAM arbiter VGA port.
REQ-008 sram_sel  output  1  read request to the SRAM arbiter.
REQ-009 sram_data  input  48  read data from the arbiter.
REQ-010 sram_valid  input  1  arbiter: sram_data is valid for sram_addr this cycle.
REQ-011 pix_rd  input  1  scan-out consumes the current pixel this cycle.
REQ-012 pix_data  output  12  current pixel {R4,G4,B4}.
REQ-013 pix_empty  output  1  no pixel available.
REQ-014 underrun  output  1  sticky underrun flag (see Configuration).

Function
REQ-015 FSM states IDLE, FETCH, FULL shall be implemented; sram_sel shall be 1 only in FETCH.
REQ-016 In FETCH, sram_addr shall hold stable until sram_valid is sampled 1.
REQ-017 On FETCH with sram_valid=1, sram_data shall be written to the FIFO tail in that cycle and sram_addr shall advance by 1 on the next edge.
REQ-018 After a capture: if the captured word was word FRAME_WORDS-1 -> IDLE; else if FIFO now full -> FULL; else remain FETCH.
REQ-019 FULL shall return to FETCH on the edge after the FIFO count drops below 2**DEPTH_LOG2.
REQ-020 sram_valid outside FETCH shall be ignored.
REQ-021 frame_start shall, on the next edge: empty the FIFO, clear the pixel index, set sram_addr=BASE_ADDR, enter FETCH; any capture in the same cycle shall be discarded.
REQ-022 frame_start shall take priority over pix_rd and capture in the same cycle.
REQ-023 Each FIFO word holds 4 pixels; pixel k (0..3) = word[12k+11:12k]; a 2-bit pixel index selects the slice of the FIFO head combinationally (zero-latency).
REQ-024 pix_rd with pix_empty=0 shall advance the pixel index; on index 3 it shall wrap to 0 and pop the head word.
REQ-025 Simultaneous push and pop shall leave the count unchanged; a push into a FIFO that is full at cycle start shall not occur (guaranteed by FSM).
REQ-026 pix_empty shall equal (FIFO count == 0).
REQ-027 pix_rd while pix_empty=1 shall not change FIFO or index state.
REQ-028 FIFO pointers shall wrap modulo 2**DEPTH_LOG2; count shall be DEPTH_LOG2+1 bits.

Reset
REQ-029 rst shall set state=IDLE, sram_addr=BASE_ADDR, sram_sel=0, FIFO count/pointers=0, pixel index=0, underrun=0.
REQ-030 While pix_empty=1, pix_data shall be 12'h000.
REQ-031 rst during an outstanding FETCH shall abandon the request; sram_sel shall be 0 in the cycle after the reset edge.
REQ-032 After reset, no fetch shall start until frame_start.

Configuration
REQ-033 Macro VGA_FETCH_UNDERRUN_EN: when defined, underrun shall be set on any cycle with pix_rd=1 and pix_empty=1, held until rst or frame_start.
REQ-034 Without VGA_FETCH_UNDERRUN_EN, underrun shall be constant 0 and no detection logic shall be built.

Verification
REQ-035 rst, then frame_start; arbiter model returns valid 1 cycle after sel with data=addr -> first word at addr 0, sram_addr increments 0,1,2...
REQ-036 No pix_rd, DEPTH_LOG2=4 -> exactly 16 captures, state FULL, sram_sel=0; one pop of 4 pix_rd -> one more fetch.
REQ-037 Head word 48'hFFF_ABC_123_456 with 4 pix_rd -> pix_data 12'h456, 12'h123, 12'hABC, 12'hFFF, then next word.
REQ-038 FRAME_WORDS=5 -> fetch addrs 0..4 only, then IDLE with sram_sel=0.
REQ-039 frame_start asserted in the same cycle as sram_valid at addr 7 -> word discarded, pix_empty=1, next sram_addr=BASE_ADDR.
REQ-040 With VGA_FETCH_UNDERRUN_EN: pix_rd on empty FIFO -> underrun=1 next cycle, held until frame_start; without the macro -> underrun stays 0.
